freq_div_sched: RTL
===================

Name: freq_div_sched

Overview:
Programmable clock-divider controller that owns the divider counter and shares divisor reconfiguration between NREQ requesters. Requests are arbitrated round-robin. A captured divisor is committed only at a period boundary, so the output is glitch-free. Start and stop are graceful: a stop always completes the current period. It sits between software/config requesters and any logic that consumes a divided clock or a period tick.

Parameters:
NREQ, 4, number of divisor requesters (2..8)
W, 8, divisor and counter width
DEFAULT_DIV, 4, active divisor after reset (must be >= 2)

Ports:
clk_in  input  1  system clock
rst  input  1  asynchronous reset, active-high
enable  input  1  run request; level-sensitive
req  input  NREQ  per-requester divisor update request; held until matching gnt
req_div  input  NREQ*W  requester i divisor at bits [i*W +: W]
gnt  output  NREQ  one-cycle pulse when requester's divisor is committed
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse on the last cycle of each period
active_div  output  W  divisor currently in effect
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, active_div=DEFAULT_DIV, pend_div=0, pend_id=0, rr_ptr=0, clk_out=0, tick=0, gnt=0.
- Clamp: any divisor < 2 (0 or 1) is committed as 2. No error is reported.
- Period end (pe): cnt == active_div-1 while in RUN/PEND/STOP.
- Counter in RUN/PEND/STOP:
  - cnt <= pe ? 0 : cnt+1.
  - tick <= pe.
  - clk_out <= (cnt < active_div>>1). clk_out lags cnt by one cycle.
  - Odd divisor D gives floor(D/2) cycles high and ceil(D/2) cycles low.
- Counter in IDLE: cnt held at 0; clk_out <= 0; tick <= 0.
- Arbitration:
  - Round-robin starting at rr_ptr; the lowest index at or after rr_ptr with req high wins.
  - On capture of winner i: rr_ptr <= (i+1) mod NREQ.
  - Arbitration runs only in IDLE and RUN.
- States:
  - IDLE:
    - Any req: commit immediately; active_div <= clamp(req_div[i]), gnt[i] pulses next cycle.
    - If enable is also high in the same cycle, go to RUN and the first period uses the new divisor.
    - enable alone: go to RUN, cnt=0.
  - RUN:
    - !enable: go to STOP. This takes priority over req.
    - Else any req: pend_div <= clamp(req_div[i]), pend_id <= i, go to PEND. No gnt yet.
  - PEND:
    - At pe: active_div <= pend_div, gnt[pend_id] pulses (registered, same edge as cnt returns to 0).
    - Then go to RUN if enable, else IDLE.
    - New reqs are not arbitrated while in PEND.
  - STOP:
    - At pe: go to IDLE.
    - If enable reasserts before pe: go to RUN, counter undisturbed.
    - Reqs wait until IDLE.
- Requester drops req after capture but before gnt: the commit still occurs and gnt still pulses (capture is final).
- Divisor change never truncates a running period. The new divisor takes effect starting at cnt=0 of the next period.
- Reset mid-PEND: pending update is discarded, no gnt, active_div returns to DEFAULT_DIV.
- At most one gnt bit is high in any cycle. gnt is never asserted for a requester whose req was low at capture.

Test Plan:
- Reset, enable=1, no reqs → active_div=4; clk_out pattern 1,1,0,0 repeating, starting one cycle after RUN entry; tick every 4th cycle; busy=1.
- In RUN (div 4) at cnt=1, req[1]=1 with div 6 → state PEND; at cnt=3 gnt[1] pulses; next period clk_out 1,1,1,0,0,0; active_div=6.
- req[0] and req[2] asserted together, rr_ptr=0, in RUN → gnt[0] at first period end; req[2] captured next, gnt[2] one period later; rr_ptr=3 afterwards.
- In IDLE, req[3]=1 with div 0 → gnt[3] next cycle; active_div=2; then enable=1 gives clk_out 1,0 alternating.
- div 5 running, enable drops at cnt=1 → cnt continues to 4, then IDLE; clk_out=0, busy=0, tick pulsed exactly once more.
- In PEND (div 4 → 7), assert rst at cnt=2 → all outputs 0 immediately; active_div=4; gnt never pulses; after release, enable restarts with the 1,1,0,0 pattern.

Source files
------------

// File: rtl/freq_div_sched.sv
// Programmable clock divider with round-robin shared divisor reconfiguration.
// Divisor updates are committed only at period boundaries, so clk_out never glitches.
module freq_div_sched #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned W           = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_div,
    output logic [NREQ-1:0]   gnt,
    output logic              clk_out,
    output logic              tick,
    output logic [W-1:0]      active_div,
    output logic              busy
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t         state;
    logic [W-1:0]   cnt;
    logic [W-1:0]   pend_div;
    logic [IDW-1:0] pend_id;
    logic [IDW-1:0] rr_ptr;

    logic           win_vld_c;
    logic [IDW-1:0] win_id_c;
    logic [IDW-1:0] nxt_ptr_c;
    logic [W-1:0]   win_div_c;
    logic           pe_c;

    function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
        return (d < W'(2)) ? W'(2) : d;
    endfunction

    // Round-robin pick: scan downward so the smallest offset from rr_ptr wins.
    always_comb begin
        win_vld_c = 1'b0;
        win_id_c  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(32'(rr_ptr) + 32'(k)) % NREQ]) begin
                win_vld_c = 1'b1;
                win_id_c  = IDW'((32'(rr_ptr) + 32'(k)) % NREQ);
            end
        end
    end

    always_comb begin
        nxt_ptr_c = (32'(win_id_c) == NREQ - 1) ? '0 : win_id_c + IDW'(1);
        win_div_c = clamp_div(req_div[32'(win_id_c) * W +: W]);
        pe_c      = (cnt == active_div - W'(1));
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            active_div <= W'(DEFAULT_DIV);
            pend_div   <= '0;
            pend_id    <= '0;
            rr_ptr     <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            gnt        <= '0;
            busy       <= 1'b0;
        end else begin
            gnt  <= '0;
            tick <= 1'b0;
            if (state == IDLE) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                // Idle commits are immediate: no period is running to protect.
                if (win_vld_c) begin
                    active_div    <= win_div_c;
                    gnt[win_id_c] <= 1'b1;
                    rr_ptr        <= nxt_ptr_c;
                end
                if (enable) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else begin
                cnt     <= pe_c ? '0 : cnt + W'(1);
                tick    <= pe_c;
                clk_out <= (cnt < (active_div >> 1));
                case (state)
                    RUN: begin
                        if (!enable) begin
                            state <= STOP;
                        end else if (win_vld_c) begin
                            pend_div <= win_div_c;
                            pend_id  <= win_id_c;
                            rr_ptr   <= nxt_ptr_c;
                            state    <= PEND;
                        end
                    end
                    PEND: begin
                        if (pe_c) begin
                            active_div   <= pend_div;
                            gnt[pend_id] <= 1'b1;
                            state        <= enable ? RUN : IDLE;
                            busy         <= enable;
                        end
                    end
                    STOP: begin
                        if (enable) begin
                            state <= RUN;
                        end else if (pe_c) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
